updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 90 +++++++++
 tb/tb_updown_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, clear, terminal-count and overflow reporting.
//
// Parameters:
//   WIDTH    - counter width in bits (2..32)
//   MODULUS  - count range is 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE - 0: wrap at the boundaries, 1: hold at the boundaries
//
// Ports:
//   clock    in   sole clock, rising edge
//   reset    in   synchronous active-low reset
//   io_en    in   count enable for this cycle
//   io_up    in   direction, 1 = increment, 0 = decrement
//   io_clear in   synchronous clear of count, wrap pulse and sticky overflow
//   io_load  in   synchronous load of io_in (clamped to MODULUS-1)
//   io_in    in   load value
//   io_out   out  current count (register)
//   io_tc    out  terminal count, combinational
//   io_wrap  out  registered one-cycle pulse after a wrap
//   io_ovf   out  sticky overflow/underflow flag (register)
module updown_counter #(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_up,
  input  logic             io_clear,
  input  logic             io_load,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] io_out,
  output logic             io_tc,
  output logic             io_wrap,
  output logic             io_ovf
);

  // MODULUS may equal 2^WIDTH, so only MODULUS-1 is ever represented in WIDTH bits.
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  always_comb begin
    boundary = io_en & (io_up ? (count_q == MaxCount) : (count_q == '0));
    io_tc    = boundary & ~io_clear & ~io_load;
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;  // pulse: cleared unless a wrap happens this cycle
    ovf_d   = ovf_q;
    if (io_clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (io_load) begin
      count_d = (io_in > MaxCount) ? MaxCount : io_in;
    end else if (io_en) begin
      if (boundary) begin
        ovf_d  = 1'b1;
        wrap_d = !SATURATE;
        if (!SATURATE) begin
          count_d = io_up ? '0 : MaxCount;
        end
      end else begin
        // Non-boundary steps stay strictly inside 0..MaxCount, so no carry escapes.
        count_d = io_up ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io_out  = count_q;
  assign io_wrap = wrap_q;
  assign io_ovf  = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances share one stimulus stream
//   a: WIDTH=4 MODULUS=10 wrap, b: WIDTH=4 MODULUS=10 saturate, c: WIDTH=4 MODULUS=16 wrap.
// Expected next states are queued when stimulus is driven and compared after the edge.
module tb_updown_counter;

  logic       clock;
  logic       reset;
  logic       io_en, io_up, io_clear, io_load;
  logic [3:0] io_in;

  logic [3:0] out_a, out_b, out_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       ovf_a, ovf_b, ovf_c;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       wrap;
    logic       ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int m_cnt [3];
  bit m_wrap[3];
  bit m_ovf [3];
  int mods  [3] = '{10, 10, 16};
  bit sats  [3] = '{1'b0, 1'b1, 1'b0};

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clock(clock), .reset(reset), .io_en(io_en), .io_up(io_up), .io_clear(io_clear),
    .io_load(io_load), .io_in(io_in), .io_out(out_a), .io_tc(tc_a), .io_wrap(wrap_a),
    .io_ovf(ovf_a)
  );

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .io_en(io_en), .io_up(io_up), .io_clear(io_clear),
    .io_load(io_load), .io_in(io_in), .io_out(out_b), .io_tc(tc_b), .io_wrap(wrap_b),
    .io_ovf(ovf_b)
  );

  updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_c (
    .clock(clock), .reset(reset), .io_en(io_en), .io_up(io_up), .io_clear(io_clear),
    .io_load(io_load), .io_in(io_in), .io_out(out_c), .io_tc(tc_c), .io_wrap(wrap_c),
    .io_ovf(ovf_c)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cmp_state(input string n, input exp_t e, input logic [3:0] o, input logic w,
                           input logic v);
    check({n, "_out"}, 32'(o), 32'(e.cnt));
    check({n, "_wrap"}, 32'(w), 32'(e.wrap));
    check({n, "_ovf"}, 32'(v), 32'(e.ovf));
  endtask

  function automatic bit model_tc(input int i);
    return io_en && !io_clear && !io_load &&
           ((io_up && m_cnt[i] == mods[i] - 1) || (!io_up && m_cnt[i] == 0));
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit bnd;
      bnd = 1'b0;
      if (!reset || io_clear) begin
        m_cnt[i] = 0;
        m_wrap[i] = 1'b0;
        m_ovf[i] = 1'b0;
      end else if (io_load) begin
        m_cnt[i] = (int'(io_in) < mods[i]) ? int'(io_in) : mods[i] - 1;
        m_wrap[i] = 1'b0;
      end else if (io_en) begin
        if (io_up) begin
          if (m_cnt[i] == mods[i] - 1) begin
            bnd = 1'b1;
            if (!sats[i]) m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            bnd = 1'b1;
            if (!sats[i]) m_cnt[i] = mods[i] - 1;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
        m_wrap[i] = bnd && !sats[i];
        if (bnd) m_ovf[i] = 1'b1;
      end else begin
        m_wrap[i] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit up, input bit clr, input bit ld,
                      input int val);
    exp_t ea, eb, ec;
    reset = rst; io_en = en; io_up = up; io_clear = clr; io_load = ld; io_in = 4'(val);
    #1;
    check("tc_a", 32'(tc_a), 32'(model_tc(0)));
    check("tc_b", 32'(tc_b), 32'(model_tc(1)));
    check("tc_c", 32'(tc_c), 32'(model_tc(2)));
    model_step();
    q_a.push_back('{cnt: 4'(m_cnt[0]), wrap: m_wrap[0], ovf: m_ovf[0]});
    q_b.push_back('{cnt: 4'(m_cnt[1]), wrap: m_wrap[1], ovf: m_ovf[1]});
    q_c.push_back('{cnt: 4'(m_cnt[2]), wrap: m_wrap[2], ovf: m_ovf[2]});
    @(posedge clock);
    #1;
    if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      ec = q_c.pop_front();
      cmp_state("a", ea, out_a, wrap_a, ovf_a);
      cmp_state("b", eb, out_b, wrap_b, ovf_b);
      cmp_state("c", ec, out_c, wrap_c, ovf_c);
    end
  endtask

  initial begin
    reset = 1'b0; io_en = 1'b0; io_up = 1'b0; io_clear = 1'b0; io_load = 1'b0; io_in = '0;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_wrap_a", 32'(wrap_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a), 32'd0);
    check("rst_tc_a", 32'(tc_a), 32'd0);

    // tc during reset follows the current count
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Up-count wrap from 0
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("up_final_a", 32'(out_a), 32'd2);
    check("up_ovf_a", 32'(ovf_a), 32'd1);
    check("up_sat_b", 32'(out_b), 32'd9);

    // Down-count saturation after load 2
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("dn_out_b", 32'(out_b), 32'd0);
    check("dn_wrap_b", 32'(wrap_b), 32'd0);
    check("dn_ovf_b", 32'(ovf_b), 32'd1);

    // Load clamp, then clear beats load
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 13);
    check("clamp_a", 32'(out_a), 32'd9);
    check("noclamp_c", 32'(out_c), 32'd13);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5);
    check("clrld_out_a", 32'(out_a), 32'd0);
    check("clrld_ovf_b", 32'(ovf_b), 32'd0);

    // Reset mid-count with ovf set
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    repeat (7) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("pre_rst_a", 32'(out_a), 32'd7);
    check("pre_rst_ovf_a", 32'(ovf_a), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("midrst_out_a", 32'(out_a), 32'd0);
    check("midrst_ovf_a", 32'(ovf_a), 32'd0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("resume_a", 32'(out_a), 32'd2);

    // Full-range modulus on instance c
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("full_dn_c", 32'(out_c), 32'd15);
    check("full_wrap_c", 32'(wrap_c), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    check("full_up_c", 32'(out_c), 32'd0);

    // Enable gating from 3
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    check("gate_a", 32'(out_a), 32'd5);

    // Random mix
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(31) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
           $urandom_range(15) == 0, $urandom_range(15) == 0, int'($urandom_range(15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
